// File: rtl/dmem_responder.sv
// dmem_responder: memory side of the core's load/store request interface.
// Latency: acceptance edge to resp_valid sampled high is LATENCY+2 cycles; one request in flight.
// Backpressure: req_ready is high only in IDLE, so a held request waits for the next IDLE cycle.
// Optional feature: define DMEM_BYTE_EN to add per-lane store enables (req_be).
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int AW      = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_EN
  input  logic [3:0]  req_be,
`endif
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  // Wait counter start value; unused when LATENCY is 0 since IDLE jumps straight to ACCESS.
  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept;

  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  lane_en;

  logic [31:0] mem [DEPTH];

  logic [AW-1:0] idx;
  logic          err;

  // Decode is done on the latched address, so the request inputs may change freely once accepted.
  assign idx = addr_q[AW+1:2];
  assign err = (addr_q[1:0] != 2'b00) || (addr_q[31:AW+2] != '0);

  // State and wait counter; reset drops any accepted request that has not reached ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic plus the handshake outputs, which are pure functions of the state.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            state_nxt = ACCESS;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = ACCESS;
        else             cnt_nxt   = cnt - 4'd1;
      end
      ACCESS: state_nxt = RESP;
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the request fields on the acceptance edge only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

`ifdef DMEM_BYTE_EN
  logic [3:0] be_q;

  // Byte enables travel with the rest of the request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         be_q <= 4'd0;
    else if (accept) be_q <= req_be;
  end

  assign lane_en = be_q;
`else
  assign lane_en = 4'hF;
`endif

  // Response registers update in ACCESS and then hold until the next access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else if (state == ACCESS) begin
      resp_err   <= err;
      resp_rdata <= (err || we_q) ? 32'd0 : mem[idx];
    end
  end

  // Store path; the rst term keeps a reset coinciding with the ACCESS edge from writing.
  always_ff @(posedge clk) begin
    if (!rst && state == ACCESS && we_q && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed steps, expected responses queued at issue and checked on resp_valid.
// Covers reset, store/load, error decode, held requests while busy, reset mid-operation,
// and byte-lane stores when DMEM_BYTE_EN is defined.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
`ifdef DMEM_BYTE_EN
  logic [3:0]  req_be = 4'hF;
`endif
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  dmem_responder #(.DEPTH(256), .AW(8), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
`ifdef DMEM_BYTE_EN
    .req_be     (req_be),
`endif
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          t;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [256];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Response monitor: every resp_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_resp", {31'd0, resp_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        check("resp_latency", 32'(cyc - e.t), 32'(LAT + 2));
      end
    end
  end

  // Called at a falling edge. Drives a request, waits for acceptance, queues the expected response.
  // With keep=0 the request is withdrawn and the busy (ready low) window is measured.
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input bit keep, output int waited);
    logic        e_err;
    logic [31:0] e_data;
    logic [3:0]  be_eff;
    int          lows;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
`ifdef DMEM_BYTE_EN
    req_be = be;
    be_eff = be;
`else
    be_eff = 4'hF & be;
    be_eff = 4'hF;
`endif
    waited = 0;
    while (req_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (req_ready !== 1'b1) begin
      check("accept_timeout", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    e_err  = (a[1:0] != 2'b00) || (a[31:10] != 22'd0);
    e_data = (we || e_err) ? 32'd0 : model[a[9:2]];
    if (we && !e_err) begin
      for (int i = 0; i < 4; i++)
        if (be_eff[i]) model[a[9:2]][8*i +: 8] = d[8*i +: 8];
    end
    sb.push_back('{e_data, e_err, cyc});
    @(negedge clk);
    if (!keep) begin
      req_valid = 1'b0;
      lows = 0;
      while (req_ready !== 1'b1 && lows < 50) begin
        lows++;
        @(negedge clk);
      end
      check("ready_low_cycles", 32'(lows), 32'(LAT + 2));
    end
  endtask

  initial begin : main
    int w;
    int seen;

    // Reset values while reset is held.
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", {31'd0, resp_err}, 32'd0);
    rst = 1'b0;

    // No spontaneous responses while idle.
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) seen++;
    end
    check("idle_no_resp", 32'(seen), 32'd0);

    // Store then load back.
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, w);
    issue(1'b0, 32'h10, 32'h0,       4'hF, 1'b0, w);

    // Known contents for later steps.
    issue(1'b1, 32'h00, 32'h12345678, 4'hF, 1'b0, w);
    issue(1'b1, 32'h04, 32'hA5A50004, 4'hF, 1'b0, w);
    issue(1'b1, 32'h08, 32'h5A5A0008, 4'hF, 1'b0, w);
    issue(1'b1, 32'h20, 32'hCAFE0020, 4'hF, 1'b0, w);

    // Misaligned load, out-of-range store, then confirm nothing was disturbed.
    issue(1'b0, 32'h13,  32'h0,       4'hF, 1'b0, w);
    issue(1'b1, 32'h400, 32'h0BAD0BAD, 4'hF, 1'b0, w);
    issue(1'b0, 32'h00,  32'h0,       4'hF, 1'b0, w);
    issue(1'b0, 32'h10,  32'h0,       4'hF, 1'b0, w);
    issue(1'b1, 32'h3FC, 32'h0000FFFC, 4'hF, 1'b0, w);
    issue(1'b0, 32'h3FC, 32'h0,       4'hF, 1'b0, w);

    // Request held through the busy window, then changed: two separate acceptances.
    issue(1'b0, 32'h04, 32'h0, 4'hF, 1'b1, w);
    issue(1'b0, 32'h08, 32'h0, 4'hF, 1'b0, w);
    check("bp_wait_cycles", 32'(w), 32'(LAT + 2));

    // Reset during WAIT: asynchronous effect, dropped store, no response.
    issue(1'b1, 32'h20, 32'h00000055, 4'hF, 1'b1, w);
    req_valid = 1'b0;
    check("busy_ready", {31'd0, req_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_ready", {31'd0, req_ready}, 32'd1);
    check("async_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("async_rst_rdata", resp_rdata, 32'd0);
    void'(sb.pop_back());
    model[8] = 32'hCAFE0020;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    issue(1'b0, 32'h20, 32'h0, 4'hF, 1'b0, w);

`ifdef DMEM_BYTE_EN
    // Byte-lane stores.
    issue(1'b1, 32'h00, 32'h11223344, 4'b1111, 1'b0, w);
    issue(1'b1, 32'h00, 32'hAABBCCDD, 4'b0101, 1'b0, w);
    issue(1'b0, 32'h00, 32'h0,        4'b0000, 1'b0, w);
    issue(1'b1, 32'h00, 32'hFFFFFFFF, 4'b0000, 1'b0, w);
    issue(1'b0, 32'h00, 32'h0,        4'b0010, 1'b0, w);
`endif

    // Let any outstanding response arrive.
    seen = 0;
    while (sb.size() != 0 && seen < 20) begin
      @(negedge clk);
      seen++;
    end
    check("drain", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory side of the CPU's load/store request interface.
- Accepts one request at a time from the core (read or write, byte address, write data), inserts a fixed number of wait states, then performs the access and returns a one-cycle response.
- Replaces the zero-latency data RAM when the core runs with a request/ready handshake, and lets the bench exercise the stall path.

Parameters:
- DEPTH, 256: number of 32-bit words stored; must be a power of two.
- AW, 8: word-index width; must equal log2(DEPTH).
- LATENCY, 2: wait cycles between acceptance and response; range 0..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  core presents a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_ready  output  1  responder can accept a request this cycle.
- resp_valid  output  1  one-cycle pulse marking a completed access.
- resp_rdata  output  32  load data; 0 for stores and errors.
- resp_err  output  1  qualifies resp_valid: misaligned or out-of-range access.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter 0. Memory array contents are not reset.
- Handshake: a request is accepted on the rising edge where req_valid && req_ready. Address, we and wdata are latched at acceptance. Inputs are ignored at all other times.
- req_ready is 1 only in IDLE. Requests held while the responder is busy wait, and are accepted on the first IDLE cycle.
- State machine:
  - IDLE: on acceptance, go to WAIT with cnt=LATENCY-1. If LATENCY=0, go directly to ACCESS.
  - WAIT: cnt decrements each cycle. When cnt==0, go to ACCESS.
  - ACCESS: perform the access on this edge and register the response. Next state is RESP.
  - RESP: resp_valid=1 for exactly this cycle. Next state is IDLE. req_ready stays 0 in RESP, so there are no back-to-back acceptances.
- Latency: acceptance edge to resp_valid high is LATENCY+2 cycles. Minimum request-to-request spacing is LATENCY+3 cycles.
- Address decode:
  - Word index is req_addr[AW+1:2].
  - Error if req_addr[1:0]!=0, or if req_addr[31:AW+2]!=0.
  - On error: no write, resp_rdata=0, resp_err=1 alongside resp_valid.
- Load: resp_rdata = mem[index], read in ACCESS.
- Store: mem[index] <= wdata in ACCESS; resp_rdata=0, resp_err=0.
- resp_rdata and resp_err hold their values until the next response. They are valid only while resp_valid=1.
- Reset mid-operation: an accepted request that has not reached ACCESS is dropped, with no write and no response. Reset asserted on the ACCESS edge wins: no write.
- A load that follows a store to the same address returns the stored data. Accesses are strictly serialized, so no hazard logic is needed.

Optional Feature:
- Macro: DMEM_BYTE_EN.
- When defined:
  - Adds input req_be[3:0], latched at acceptance.
  - Stores write only the byte lanes whose bit is set; be[0] selects bits 7:0.
  - be=0000 is a legal no-op store with resp_err=0.
  - Loads ignore be and always return the full word.
- When undefined: no req_be port, and every store writes all 32 bits.

Test Plan:
- Reset then idle: assert rst asynchronously mid-cycle -> req_ready=1, resp_valid=0, resp_rdata=0 immediately. After release, no spontaneous resp_valid for 20 cycles.
- Store then load, LATENCY=2:
  - Store 0xDEADBEEF to 0x10 -> resp_valid 4 cycles after acceptance with err=0, rdata=0.
  - Load 0x10 -> rdata=0xDEADBEEF.
  - req_ready is low for exactly 4 cycles after each acceptance.
- Errors:
  - Load 0x13 (misaligned) -> resp_err=1, rdata=0, no memory change.
  - Store to 0x400 with DEPTH=256 -> resp_err=1; a load of 0x0 still returns its prior value.
- Back-pressure: hold req_valid high with a load of 0x4, then switch to a load of 0x8 while busy -> only the first is accepted. The second is accepted on the next IDLE cycle and gets a separate response.
- Reset mid-op: accept a store 0x55 to 0x20, assert rst in WAIT -> no resp_valid. A later load of 0x20 returns the old value.
- With DMEM_BYTE_EN:
  - Write 0x11223344 to 0x0 with be=1111.
  - Store 0xAABBCCDD with be=0101 -> load returns 0x11BB33DD.
  - Store with be=0000 -> value unchanged.
